// File: rtl/tdm_serializer.sv
// Five-channel parallel-to-serial TDM framer with a one-frame holding register for gapless streaming.
// Optional underrun counter output is enabled by defining TDM_UNDERRUN_CNT_EN.
module tdm_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int FRAME_GAP  = 0
) (
    input  logic                  tdm_clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] ch0,
    input  logic [WORD_WIDTH-1:0] ch1,
    input  logic [WORD_WIDTH-1:0] ch2,
    input  logic [WORD_WIDTH-1:0] ch3,
    input  logic [WORD_WIDTH-1:0] ch4,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  tdm_data,
    output logic                  tdm_sync,
    output logic                  frame_done,
`ifdef TDM_UNDERRUN_CNT_EN
    output logic [7:0]            underrun_count,
`endif
    output logic                  busy
);

    localparam int FW = 5 * WORD_WIDTH;
    localparam int CW = $clog2(FW);
    localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);
    localparam logic [CW-1:0] PENULT_BIT = CW'(FW - 2);
    localparam logic [GW-1:0] GAP_LAST = (FRAME_GAP > 0) ? GW'(FRAME_GAP - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            hold_full_q, hold_full_d;
    logic            data_q, data_d;
    logic            sync_q, sync_d;
    logic            done_q, done_d;
    logic [FW-1:0]   shreg_q, shreg_d;
    logic [FW-1:0]   hold_q, hold_d;
    logic            load_fire;
    logic            start_frame;

    assign load_fire = load_valid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        hold_full_d = hold_full_q;
        data_d      = 1'b0;
        sync_d      = 1'b0;
        done_d      = 1'b0;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        start_frame = 1'b0;

        if (load_fire) begin
            hold_d      = {ch0, ch1, ch2, ch3, ch4};
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    start_frame = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (FRAME_GAP == 0) begin
                        if (hold_full_q) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end
                end else begin
                    // MSB of the shifter is always the bit currently on the wire
                    shreg_d   = shreg_q << 1;
                    data_d    = shreg_q[FW-2];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    done_d    = (bit_cnt_q == PENULT_BIT);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (hold_full_q) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load can never coincide with a start: both depend on opposite hold_full_q values
        if (start_frame) begin
            shreg_d     = hold_q;
            data_d      = hold_q[FW-1];
            sync_d      = 1'b1;
            bit_cnt_d   = '0;
            hold_full_d = 1'b0;
            state_d     = ST_SHIFT;
        end
    end

    always_ff @(posedge tdm_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            hold_full_q <= 1'b0;
            data_q      <= 1'b0;
            sync_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            hold_full_q <= hold_full_d;
            data_q      <= data_d;
            sync_q      <= sync_d;
            done_q      <= done_d;
        end
    end

    // Payload registers carry no reset; hold_full_q and state_q decide whether they are meaningful
    always_ff @(posedge tdm_clk) begin
        shreg_q <= shreg_d;
        hold_q  <= hold_d;
    end

    assign load_ready = !hold_full_q;
    assign tdm_data   = data_q;
    assign tdm_sync   = sync_q;
    assign frame_done = done_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef TDM_UNDERRUN_CNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] ucnt_q, ucnt_d;
    logic       frame_end;

    // A frame ends with nothing queued: the stream is about to idle or gap without a successor
    always_comb begin
        frame_end = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
        ucnt_d    = ucnt_q;
        if (frame_end && !hold_full_q) begin
            ucnt_d = sat_inc8(ucnt_q);
        end
    end

    always_ff @(posedge tdm_clk or posedge reset) begin
        if (reset) begin
            ucnt_q <= 8'd0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_tdm_serializer.sv
// Bench for tdm_serializer: two instances (FRAME_GAP 0 and 3) share stimulus and are each checked
// every cycle against a frame-timeline model; underrun checks appear when TDM_UNDERRUN_CNT_EN is set.
module tb_tdm_serializer;

    localparam int WW = 32;
    localparam int FW = 5 * WW;

    logic          tdm_clk = 1'b0;
    logic          reset;
    logic [WW-1:0] ch0, ch1, ch2, ch3, ch4;
    logic          load_valid;
    logic          rdy [2];
    logic          dat [2];
    logic          syn [2];
    logic          dn  [2];
    logic          bsy [2];
    logic [7:0]    ucnt_o [2];

    always #5 tdm_clk = ~tdm_clk;

    tdm_serializer #(.WORD_WIDTH(WW), .FRAME_GAP(0)) u_g0 (
        .tdm_clk(tdm_clk), .reset(reset),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
        .load_valid(load_valid), .load_ready(rdy[0]),
        .tdm_data(dat[0]), .tdm_sync(syn[0]), .frame_done(dn[0]),
`ifdef TDM_UNDERRUN_CNT_EN
        .underrun_count(ucnt_o[0]),
`endif
        .busy(bsy[0])
    );

    tdm_serializer #(.WORD_WIDTH(WW), .FRAME_GAP(3)) u_g3 (
        .tdm_clk(tdm_clk), .reset(reset),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
        .load_valid(load_valid), .load_ready(rdy[1]),
        .tdm_data(dat[1]), .tdm_sync(syn[1]), .frame_done(dn[1]),
`ifdef TDM_UNDERRUN_CNT_EN
        .underrun_count(ucnt_o[1]),
`endif
        .busy(bsy[1])
    );

`ifndef TDM_UNDERRUN_CNT_EN
    assign ucnt_o[0] = 8'd0;
    assign ucnt_o[1] = 8'd0;
`endif

    // Reference model: a list of frames, each with its accept edge, first-bit cycle and words
    int            gapv [2] = '{0, 3};
    longint        f_acc [2][8];
    longint        f_st  [2][8];
    logic [WW-1:0] f_w   [2][8][5];
    int            nfr [2];
    longint        last_st [2];
    bit            have_last [2];
    int            ucnt_m [2];
    longint        sync_prev [2];
    longint        sync_last [2];
    longint        cyc;
    int            checks;
    int            errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic string tg(input string n, input int d);
        return $sformatf("%s_g%0d", n, gapv[d]);
    endfunction

    function automatic int nvalid(input int d);
        return (nfr[d] < 8) ? nfr[d] : 8;
    endfunction

    // Holding register is full from its accept edge up to (not including) its start edge
    function automatic bit ready_at(input int d, input longint t);
        for (int j = 0; j < nvalid(d); j++)
            if (f_acc[d][j] <= t && t < f_st[d][j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            nfr[d] = 0;
            have_last[d] = 1'b0;
            ucnt_m[d] = 0;
        end
    endtask

    task automatic model_edge(input longint e);
        for (int d = 0; d < 2; d++) begin
            bit     full;
            longint st;
            int     slot;
            full = 1'b0;
            for (int j = 0; j < nvalid(d); j++)
                if (f_acc[d][j] <= e - 1 && f_st[d][j] >= e) full = 1'b1;
            for (int j = 0; j < nvalid(d); j++)
                if (f_st[d][j] + FW == e && !full && ucnt_m[d] < 255) ucnt_m[d]++;
            if (load_valid && ready_at(d, e - 1)) begin
                st = e + 1;
                if (have_last[d] && last_st[d] + FW + gapv[d] > st) st = last_st[d] + FW + gapv[d];
                slot = nfr[d] % 8;
                f_acc[d][slot] = e;
                f_st[d][slot]  = st;
                f_w[d][slot][0] = ch0;
                f_w[d][slot][1] = ch1;
                f_w[d][slot][2] = ch2;
                f_w[d][slot][3] = ch3;
                f_w[d][slot][4] = ch4;
                nfr[d]++;
                last_st[d] = st;
                have_last[d] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input longint t);
        for (int d = 0; d < 2; d++) begin
            logic e_data, e_sync, e_done, e_busy;
            int   k;
            e_data = 1'b0; e_sync = 1'b0; e_done = 1'b0; e_busy = 1'b0;
            for (int j = 0; j < nvalid(d); j++) begin
                k = int'(t - f_st[d][j]);
                if (k >= 0 && k < FW) begin
                    e_data = f_w[d][j][k / WW][WW - 1 - (k % WW)];
                    e_sync = (k == 0);
                    e_done = (k == FW - 1);
                end
                if (k >= 0 && k < FW + gapv[d]) e_busy = 1'b1;
            end
            chk(tg("tdm_data", d), 32'(dat[d]), 32'(e_data));
            chk(tg("tdm_sync", d), 32'(syn[d]), 32'(e_sync));
            chk(tg("frame_done", d), 32'(dn[d]), 32'(e_done));
            chk(tg("busy", d), 32'(bsy[d]), 32'(e_busy));
            chk(tg("load_ready", d), 32'(rdy[d]), 32'(ready_at(d, t)));
`ifdef TDM_UNDERRUN_CNT_EN
            chk(tg("underrun", d), 32'(ucnt_o[d]), 32'(ucnt_m[d]));
`endif
            if (syn[d] === 1'b1) begin
                sync_prev[d] = sync_last[d];
                sync_last[d] = t;
            end
        end
    endtask

    task automatic tick();
        @(posedge tdm_clk);
        cyc++;
        model_edge(cyc);
        @(negedge tdm_clk);
        check_outputs(cyc);
    endtask

    task automatic rand_ch();
        ch0 = $urandom; ch1 = $urandom; ch2 = $urandom; ch3 = $urandom; ch4 = $urandom;
    endtask

    task automatic do_reset(input int n);
        #2 reset = 1'b1;
        load_valid = 1'b0;
        #1;
        model_clear();
        for (int d = 0; d < 2; d++) begin
            chk(tg("rst_data", d), 32'(dat[d]), 32'd0);
            chk(tg("rst_sync", d), 32'(syn[d]), 32'd0);
            chk(tg("rst_done", d), 32'(dn[d]), 32'd0);
            chk(tg("rst_busy", d), 32'(bsy[d]), 32'd0);
            chk(tg("rst_ready", d), 32'(rdy[d]), 32'd1);
`ifdef TDM_UNDERRUN_CNT_EN
            chk(tg("rst_underrun", d), 32'(ucnt_o[d]), 32'd0);
`endif
        end
        repeat (n) tick();
        #2 reset = 1'b0;
    endtask

    task automatic load_frame(input logic [WW-1:0] a, b, c, dd, e);
        int n0;
        int guard;
        n0 = nfr[0];
        guard = 0;
        ch0 = a; ch1 = b; ch2 = c; ch3 = dd; ch4 = e;
        load_valid = 1'b1;
        do begin
            tick();
            guard++;
        end while (nfr[0] == n0 && guard < 1000);
        load_valid = 1'b0;
        chk("load_accept", 32'(nfr[0] != n0), 32'd1);
        rand_ch();
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        repeat (n) begin
            rand_ch();
            tick();
        end
    endtask

    task automatic rand_phase(input int n, input int pct);
        repeat (n) begin
            load_valid = ($urandom_range(0, 99) < pct);
            rand_ch();
            tick();
        end
        load_valid = 1'b0;
    endtask

    initial begin
        longint st_a;
        longint sl [2];
        checks = 0;
        errors = 0;
        cyc = 0;
        reset = 1'b1;
        load_valid = 1'b0;
        ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0; ch4 = '0;
        for (int d = 0; d < 2; d++) begin
            sync_prev[d] = -1;
            sync_last[d] = -1;
        end
        model_clear();

        do_reset(2);

        // Single frame with the reference words, then idle
        load_frame(32'h555555FA, 32'h555555FB, 32'h555555FC, 32'h555555FE, 32'h555555FF);
        idle(200);

        // Second frame queued mid-frame: back-to-back on g0, three-bit gap on g3
        load_frame($urandom, $urandom, $urandom, $urandom, $urandom);
        idle(50);
        load_frame($urandom, $urandom, $urandom, $urandom, $urandom);
        idle(400);
        chk("sync_spacing_g0", 32'(sync_last[0] - sync_prev[0]), 32'(FW));
        chk("sync_spacing_g3", 32'(sync_last[1] - sync_prev[1]), 32'(FW + 3));

        // load_valid held high with changing channels, then random traffic
        rand_phase(500, 100);
        rand_phase(1500, 30);
        idle(400);

        // Reset at bit 70 with a second frame queued
        load_frame($urandom, $urandom, $urandom, $urandom, $urandom);
        st_a = f_st[0][(nfr[0] - 1) % 8];
        load_frame($urandom, $urandom, $urandom, $urandom, $urandom);
        while (cyc < st_a + 70 && cyc < st_a + 1000) tick();
        chk("bit70_reached", 32'(cyc == st_a + 70), 32'd1);
        do_reset(3);
        sl[0] = sync_last[0];
        sl[1] = sync_last[1];
        idle(300);
        chk("no_sync_after_reset_g0", 32'(sync_last[0] == sl[0]), 32'd1);
        chk("no_sync_after_reset_g3", 32'(sync_last[1] == sl[1]), 32'd1);
        load_frame($urandom, $urandom, $urandom, $urandom, $urandom);
        idle(200);

`ifdef TDM_UNDERRUN_CNT_EN
        do_reset(2);
        repeat (3) begin
            load_frame($urandom, $urandom, $urandom, $urandom, $urandom);
            idle(FW + 8);
        end
        chk("underrun3_g0", 32'(ucnt_o[0]), 32'd3);
        chk("underrun3_g3", 32'(ucnt_o[1]), 32'd3);
        repeat (297) begin
            load_frame($urandom, $urandom, $urandom, $urandom, $urandom);
            idle(FW + 6);
        end
        chk("underrun_sat_g0", 32'(ucnt_o[0]), 32'd255);
        chk("underrun_sat_g3", 32'(ucnt_o[1]), 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
